// File: rtl/mem_arbiter_pkg.sv
// Shared types and funct3 codes for the memory-port arbiter and its lane formatter.
package mem_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef enum logic {OWNER_IF, OWNER_LS} arb_owner_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Illegal width code for the direction, or a halfword/word access off its natural boundary.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        if (we) begin
            legal = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        end else begin
            legal = (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
                    (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: store byte enables and data replication, load lane
// select with sign/zero extension, and data-access error detection.
module mem_lane_fmt
    import mem_arbiter_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        req_err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_err = access_err(req_we, req_funct3, req_addr_lo);

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        if (req_we) begin
            case (req_funct3)
                FUNCT3_SB: begin
                    st_be    = 4'b0001 << req_addr_lo;
                    st_wdata = {4{req_wdata[7:0]}};
                end
                FUNCT3_SH: begin
                    st_be    = 4'b0011 << {req_addr_lo[1], 1'b0};
                    st_wdata = {2{req_wdata[15:0]}};
                end
                FUNCT3_SW: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
                default: ;
            endcase
        end
    end

    assign ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    assign ld_byte    = ld_shifted[7:0];
    assign ld_half    = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        ld_data = 32'h0;
        case (ld_funct3)
            FUNCT3_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            FUNCT3_LBU: ld_data = {24'h0, ld_byte};
            FUNCT3_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            FUNCT3_LHU: ld_data = {16'h0, ld_half};
            FUNCT3_LW:  ld_data = ld_rdata;
            default:    ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch and load/store, one access in flight.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate when both requesters are pending.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [2:0]  ls_funct3_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [2:0]  LAT_M1    = 3'(MEM_LATENCY - 1);
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    arb_state_t  state_q;
    arb_owner_t  owner_q;
    logic [2:0]  cnt_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        we_q;
    logic        err_q;

    logic        done;
    logic        can_grant;
    logic        prefer_ls;
    logic        if_gnt;
    logic        ls_gnt;
    logic        fmt_err;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] ld_data;

    assign done      = (state_q == ARB_BUSY) && (cnt_q == 3'd0);
    // The response cycle doubles as an idle cycle so a new grant can go out back-to-back.
    assign can_grant = rst_n && ((state_q == ARB_IDLE) || done);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_t last_q;
    assign prefer_ls = (last_q == OWNER_IF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWNER_IF;
        end else if (ls_gnt) begin
            last_q <= OWNER_LS;
        end else if (if_gnt) begin
            last_q <= OWNER_IF;
        end
    end
`else
    assign prefer_ls = 1'b1;
`endif

    assign ls_gnt   = can_grant && ls_req_i && (prefer_ls || !if_req_i);
    assign if_gnt   = can_grant && if_req_i && !ls_gnt;
    assign ls_gnt_o = ls_gnt;
    assign if_gnt_o = if_gnt;

    mem_lane_fmt u_lane_fmt (
        .req_we      (ls_we_i),
        .req_funct3  (ls_funct3_i),
        .req_addr_lo (ls_addr_i[1:0]),
        .req_wdata   (ls_wdata_i),
        .st_be       (fmt_be),
        .st_wdata    (fmt_wdata),
        .req_err     (fmt_err),
        .ld_funct3   (funct3_q),
        .ld_addr_lo  (addr_lo_q),
        .ld_rdata    (mem_rdata_i),
        .ld_data     (ld_data)
    );

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = 32'h0;
        if (ls_gnt && !fmt_err) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i & WORD_MASK;
            mem_be_o    = fmt_be;
            mem_wdata_o = fmt_wdata;
        end else if (if_gnt) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i & WORD_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_IF;
            cnt_q     <= 3'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
        end else if (ls_gnt || if_gnt) begin
            state_q   <= ARB_BUSY;
            cnt_q     <= LAT_M1;
            owner_q   <= ls_gnt ? OWNER_LS : OWNER_IF;
            funct3_q  <= ls_gnt ? ls_funct3_i : 3'd0;
            addr_lo_q <= ls_gnt ? ls_addr_i[1:0] : 2'd0;
            we_q      <= ls_gnt && ls_we_i;
            err_q     <= ls_gnt && fmt_err;
        end else if (state_q == ARB_BUSY) begin
            if (cnt_q == 3'd0) begin
                state_q <= ARB_IDLE;
            end else begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    assign if_rvalid_o = done && (owner_q == OWNER_IF);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    assign ls_rvalid_o = done && (owner_q == OWNER_LS);
    assign ls_err_o    = ls_rvalid_o && err_q;
    assign ls_rdata_o  = (ls_rvalid_o && !err_q && !we_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench: latency-1 instance for function, latency-3 instance for reset abort.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] mem_rdata;

    logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_ls_err, a_mem_en, a_mem_we;
    logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_ls_err, b_mem_en, b_mem_we;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    typedef struct {
        logic        is_ls;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(a_if_gnt),
        .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_funct3_i(ls_funct3), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(a_ls_gnt), .ls_rvalid_o(a_ls_rvalid),
        .ls_rdata_o(a_ls_rdata), .ls_err_o(a_ls_err),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr), .mem_be_o(a_mem_be),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt),
        .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_funct3_i(ls_funct3), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid),
        .ls_rdata_o(b_ls_rdata), .ls_err_o(b_ls_err),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr), .mem_be_o(b_mem_be),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard entry for the next response seen on dut_a within a bounded window.
    task automatic wait_resp(input string tag, input logic is_ls);
        resp_t r;
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = is_ls ? a_ls_rvalid : a_if_rvalid;
        end
        chk({tag, ".rvalid"}, 32'(seen), 32'd1);
        r = sb_q.pop_front();
        chk({tag, ".rdata"}, is_ls ? a_ls_rdata : a_if_rdata, r.data);
        if (r.is_ls) chk({tag, ".err"}, 32'(a_ls_err), 32'(r.err));
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] rword);
        bit seen = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr; mem_rdata = rword;
        sb_q.push_back('{is_ls: 1'b0, data: rword, err: 1'b0});
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = a_if_gnt;
        end
        chk({tag, ".gnt"}, 32'(seen), 32'd1);
        chk({tag, ".addr"}, a_mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".en"}, 32'(a_mem_en), 32'd1);
        chk({tag, ".we"}, 32'(a_mem_we), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_resp(tag, 1'b0);
    endtask

    task automatic ls_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input logic exp_en,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd,
                             input logic [31:0] exp_rd, input logic exp_err);
        bit seen = 1'b0;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
        mem_rdata = rword;
        sb_q.push_back('{is_ls: 1'b1, data: exp_rd, err: exp_err});
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = a_ls_gnt;
        end
        chk({tag, ".gnt"}, 32'(seen), 32'd1);
        chk({tag, ".en"}, 32'(a_mem_en), 32'(exp_en));
        chk({tag, ".we"}, 32'(a_mem_we), 32'(exp_en && we));
        chk({tag, ".addr"}, a_mem_addr, exp_en ? (addr & 32'hFFFF_FFFC) : 32'h0);
        if (we) begin
            chk({tag, ".be"}, 32'(a_mem_be), 32'(exp_be));
            chk({tag, ".wdata"}, a_mem_wdata, exp_wd);
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
        wait_resp(tag, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        int hit_at;
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h8; ls_req = 1'b1; ls_we = 1'b0;
        ls_funct3 = 3'b010; ls_addr = 32'h100; ls_wdata = 32'h0; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.if_gnt", 32'(a_if_gnt), 32'd0);
        chk("rst.ls_gnt", 32'(a_ls_gnt), 32'd0);
        chk("rst.mem_en", 32'(a_mem_en), 32'd0);
        chk("rst.mem_addr", a_mem_addr, 32'h0);
        chk("rst.if_rdata", a_if_rdata, 32'h0);
        chk("rst.ls_rvalid", 32'(a_ls_rvalid), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0; rst_n = 1'b1;

        fetch("fetch4", 32'h0000_0004, 32'h0000_0013);

        // Both pending for two rounds, then load/store drops out.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_we = 1'b0;
        ls_funct3 = 3'b010; ls_addr = 32'h100; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("arb1.ls_gnt", 32'(a_ls_gnt), 32'd1);
        chk("arb1.if_gnt", 32'(a_if_gnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("arb2.ls_rvalid", 32'(a_ls_rvalid), 32'd1);
        chk("arb2.ls_rdata", a_ls_rdata, 32'h1111_2222);
        chk("arb2.ls_gnt", 32'(a_ls_gnt), 32'(!RR));
        chk("arb2.if_gnt", 32'(a_if_gnt), 32'(RR));
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(negedge clk);
        chk("arb3.ls_rvalid", 32'(a_ls_rvalid), 32'(!RR));
        chk("arb3.if_rvalid", 32'(a_if_rvalid), 32'(RR));
        chk("arb3.if_gnt", 32'(a_if_gnt), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("arb4.if_rvalid", 32'(a_if_rvalid), 32'd1);
        chk("arb4.if_rdata", a_if_rdata, 32'h1111_2222);

        ls_access("sb", 1'b1, 3'b000, 32'h203, 32'h0000_00AB, 32'h0, 1'b1, 4'b1000,
                  32'hABAB_ABAB, 32'h0, 1'b0);
        ls_access("sh", 1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 1'b1, 4'b1100,
                  32'h1234_1234, 32'h0, 1'b0);
        ls_access("sw", 1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b1111,
                  32'hDEAD_BEEF, 32'h0, 1'b0);
        ls_access("lb3", 1'b0, 3'b000, 32'h303, 32'h0, 32'h80FF_7F01, 1'b1, 4'b0000,
                  32'h0, 32'hFFFF_FF80, 1'b0);
        ls_access("lbu1", 1'b0, 3'b100, 32'h301, 32'h0, 32'h80FF_7F01, 1'b1, 4'b0000,
                  32'h0, 32'h0000_007F, 1'b0);
        ls_access("lh2", 1'b0, 3'b001, 32'h302, 32'h0, 32'h80FF_7F01, 1'b1, 4'b0000,
                  32'h0, 32'hFFFF_80FF, 1'b0);
        ls_access("lhu2", 1'b0, 3'b101, 32'h302, 32'h0, 32'h80FF_7F01, 1'b1, 4'b0000,
                  32'h0, 32'h0000_80FF, 1'b0);
        ls_access("lw0", 1'b0, 3'b010, 32'h300, 32'h0, 32'h80FF_7F01, 1'b1, 4'b0000,
                  32'h0, 32'h80FF_7F01, 1'b0);
        ls_access("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFF_FFFF, 1'b0, 4'b0000,
                  32'h0, 32'h0, 1'b1);
        ls_access("ld_ill", 1'b0, 3'b011, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b0, 4'b0000,
                  32'h0, 32'h0, 1'b1);
        ls_access("sh_mis", 1'b1, 3'b001, 32'h201, 32'h0000_5678, 32'h0, 1'b0, 4'b0000,
                  32'h0, 32'h0, 1'b1);

        // Latency-3 instance: clean reset, then one normal fetch.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("l3.gnt", 32'(b_if_gnt), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        hits = 0; hit_at = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (b_if_rvalid) begin
                hits++;
                hit_at = k;
                chk("l3.rdata", b_if_rdata, 32'h0000_0055);
            end
        end
        chk("l3.hits", 32'(hits), 32'd1);
        chk("l3.hit_at", 32'(hit_at), 32'd3);

        // Grant, then reset at T+1 with a request held: the in-flight response must vanish.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        chk("abort.gnt", 32'(b_if_gnt), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; if_addr = 32'h30;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort.rvalid", 32'(b_if_rvalid), 32'd0);
            chk("abort.gnt_rst", 32'(b_if_gnt), 32'd0);
            chk("abort.mem_en", 32'(b_mem_en), 32'd0);
            chk("abort.mem_addr", b_mem_addr, 32'h0);
            chk("abort.if_rdata", b_if_rdata, 32'h0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("fresh.gnt", 32'(b_if_gnt), 32'd1);
        chk("fresh.addr", b_mem_addr, 32'h30);
        @(posedge clk); #1;
        if_req = 1'b0;
        hits = 0; hit_at = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (b_if_rvalid) begin
                hits++;
                hit_at = k;
            end
        end
        chk("fresh.hits", 32'(hits), 32'd1);
        chk("fresh.hit_at", 32'(hit_at), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
